// File: rtl/scrambler_tx.sv
// 64b/66b transmit scrambler (G(x) = 1 + x^39 + x^58) with idle-block insertion.
// A one-deep output register feeds the gearbox, and accept_i stalls the whole block.
module scrambler_tx #(
  parameter int          DATA_W = 64,
  parameter int          HEAD_W = 2,
  parameter int          BYPASS = 0,
  parameter logic [57:0] SEED   = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  input  logic              accept_i,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o,
  output logic              idle_o
);

  localparam int                ST_W         = 58;
  localparam int                EXT_W        = ST_W + DATA_W;
  localparam logic [HEAD_W-1:0] HEAD_CTRL    = HEAD_W'(2'b10);
  localparam logic [DATA_W-1:0] IDLE_PAYLOAD = DATA_W'(8'h1E);

  // The history and the new bits sit in one vector: ext[ST_W+n] = s[n],
  // so s[n-39] = ext[n+19] and s[n-58] = ext[n] for every n.
  function automatic logic [DATA_W-1:0] scramble(input logic [ST_W-1:0]   st,
                                                 input logic [DATA_W-1:0] d);
    logic [EXT_W-1:0] ext;
    ext           = '0;
    ext[ST_W-1:0] = st;
    for (int n = 0; n < DATA_W; n++) begin
      ext[ST_W+n] = d[n] ^ ext[n+19] ^ ext[n];
    end
    return ext[EXT_W-1 -: DATA_W];
  endfunction

  logic [ST_W-1:0]   st_q, st_d;
  logic [HEAD_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              idle_q, idle_d;

  logic [HEAD_W-1:0] sel_head;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] scr_data;

  assign ready_o = accept_i;

  always_comb begin
    sel_head = valid_i ? head_i : HEAD_CTRL;
    sel_data = valid_i ? data_i : IDLE_PAYLOAD;
    scr_data = scramble(st_q, sel_data);

    st_d   = st_q;
    head_d = head_q;
    data_d = data_q;
    idle_d = idle_q;

    if (accept_i) begin
      // State always follows the scrambled stream, so bypass cannot desync a later link.
      st_d   = scr_data[DATA_W-1 -: ST_W];
      head_d = sel_head;
      data_d = (BYPASS != 0) ? sel_data : scr_data;
      idle_d = ~valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      st_q   <= SEED;
      head_q <= '0;
      data_q <= '0;
      idle_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      head_q <= head_d;
      data_q <= data_d;
      idle_q <= idle_d;
    end
  end

  assign head_o = head_q;
  assign data_o = data_q;
  assign idle_o = idle_q;

endmodule

// File: tb/tb_scrambler_tx.sv
// Bench for scrambler_tx: a bit-serial reference scrambler and descrambler,
// with a scrambling and a bypass instance driven from the same inputs.
module tb_scrambler_tx;

  logic        clk = 1'b0;
  logic        nreset;
  logic        valid_i;
  logic [1:0]  head_i;
  logic [63:0] data_i;
  logic        accept_i;
  logic        ready_o, ready_b;
  logic [1:0]  head_o, head_b;
  logic [63:0] data_o, data_b;
  logic        idle_o, idle_b;

  always #5 clk = ~clk;

  scrambler_tx #(.BYPASS(0)) dut (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .head_i(head_i), .data_i(data_i),
    .ready_o(ready_o), .accept_i(accept_i), .head_o(head_o), .data_o(data_o), .idle_o(idle_o)
  );

  scrambler_tx #(.BYPASS(1)) dut_byp (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .head_i(head_i), .data_i(data_i),
    .ready_o(ready_b), .accept_i(accept_i), .head_o(head_b), .data_o(data_b), .idle_o(idle_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference histories, oldest bit first; always 58 entries.
  bit          sh[$];
  bit          dh[$];
  int          desc_blocks;
  logic [1:0]  e_head;
  logic [63:0] e_data;
  logic [63:0] e_pay;
  logic        e_idle;

  task automatic model_reset();
    sh.delete();
    dh.delete();
    for (int i = 0; i < 58; i++) begin
      sh.push_back(1'b1);
      dh.push_back(1'b0);
    end
    desc_blocks = 0;
    e_head = 2'b00;
    e_data = 64'h0;
    e_pay  = 64'h0;
    e_idle = 1'b0;
  endtask

  task automatic model_scramble(input logic [63:0] d, output logic [63:0] s);
    bit b;
    for (int n = 0; n < 64; n++) begin
      b = d[n] ^ sh[19] ^ sh[0];
      s[n] = b;
      sh.push_back(b);
      void'(sh.pop_front());
    end
  endtask

  task automatic model_descramble(input logic [63:0] s, output logic [63:0] d);
    for (int n = 0; n < 64; n++) begin
      d[n] = s[n] ^ dh[19] ^ dh[0];
      dh.push_back(s[n]);
      void'(dh.pop_front());
    end
  endtask

  task automatic cycle(input logic v, input logic [1:0] h, input logic [63:0] d,
                       input logic acc, input logic rst_n);
    logic [63:0] pay, s, dd;
    logic        adv;
    valid_i  = v;
    head_i   = h;
    data_i   = d;
    accept_i = acc;
    nreset   = rst_n;
    #1;
    check_eq("ready", ready_o, acc);
    check_eq("ready_byp", ready_b, acc);
    @(posedge clk);
    adv = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (acc) begin
      adv = 1'b1;
      pay = v ? d : 64'h1E;
      model_scramble(pay, s);
      e_head = v ? h : 2'b10;
      e_data = s;
      e_pay  = pay;
      e_idle = ~v;
    end
    #1;
    check_eq("head", head_o, e_head);
    check_eq("data", data_o, e_data);
    check_eq("idle", idle_o, e_idle);
    check_eq("byp_head", head_b, e_head);
    check_eq("byp_data", data_b, e_pay);
    check_eq("byp_idle", idle_b, e_idle);
    if (adv) begin
      model_descramble(data_o, dd);
      desc_blocks++;
      if (desc_blocks >= 2) check_eq("descramble", dd, e_pay);
    end
  endtask

  task automatic stream(input int cycles);
    logic        v, acc;
    logic [1:0]  h;
    logic [63:0] d;
    for (int i = 0; i < cycles; i++) begin
      acc = (i % 33) != 32;
      v   = $urandom_range(0, 7) != 0;
      h   = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      d   = {$urandom, $urandom};
      cycle(v, h, d, acc, 1'b1);
    end
  endtask

  logic [63:0] held;

  initial begin
    model_reset();
    valid_i  = 1'b0;
    head_i   = 2'b00;
    data_i   = 64'h0;
    accept_i = 1'b0;
    nreset   = 1'b0;

    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 2'b01, {$urandom, $urandom}, ($urandom_range(0, 1) != 0), 1'b0);
    end

    cycle(1'b1, 2'b01, 64'h0, 1'b1, 1'b1);
    check_eq("golden_first", data_o, 64'h03FF_FF80_0000_0000);

    held = data_o;
    cycle(1'b1, 2'b10, {$urandom, $urandom}, 1'b0, 1'b1);
    check_eq("hold_data", data_o, held);
    cycle(1'b1, 2'b01, {$urandom, $urandom}, 1'b1, 1'b1);

    cycle(1'b0, 2'b01, 64'h0, 1'b1, 1'b1);
    check_eq("idle_head", head_o, 2'b10);
    check_eq("idle_flag", idle_o, 1'b1);

    cycle(1'b1, 2'b01, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b1);
    check_eq("bypass_deadbeef", data_b, 64'hDEAD_BEEF_0123_4567);

    stream(500);

    cycle(1'b1, 2'b01, {$urandom, $urandom}, 1'b1, 1'b0);
    check_eq("midrst_data", data_o, 64'h0);
    cycle(1'b1, 2'b01, 64'h0, 1'b1, 1'b1);
    check_eq("post_reset_golden", data_o, 64'h03FF_FF80_0000_0000);

    stream(600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
